// File: rtl/pipe_reg_fifo.sv
// pipe_reg_fifo: DEPTH-entry elastic pipeline stage with valid/ready handshake, flush and bubble output.
module pipe_reg_fifo #(
    parameter int CTRL_WIDTH = 34,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]         count
);
    logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // in_ready looks only at registered occupancy so downstream stalls never reach upstream combinationally
    always_comb begin
        in_ready  = !flush && count < CW'(DEPTH);
        out_valid = !flush && count != '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : '0;
        out_data  = out_valid ? data_mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // storage is left unreset; outputs are masked whenever the stage is empty
    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr] <= in_ctrl;
            data_mem[wr_ptr] <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_reg_fifo.sv
// tb_pipe_reg_fifo: checks DEPTH=1,2,3 stages against a queue model under directed and random traffic.
module tb_pipe_reg_fifo;
    logic clk = 1'b0;
    logic rset;
    always #5 clk = ~clk;

    logic [2:0]  flush, in_valid, out_ready, in_ready, out_valid, en;
    logic [33:0] in_ctrl [3];
    logic [33:0] out_ctrl [3];
    logic [31:0] in_data [3];
    logic [31:0] out_data [3];
    logic        c0;
    logic [1:0]  c1, c2;

    int checks = 0;
    int failures = 0;
    int dep [3] = '{1, 2, 3};
    logic [65:0] q [3][$];
    logic [65:0] src [3][$];

    pipe_reg_fifo #(.DEPTH(1)) u0 (
        .clk(clk), .rset(rset), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_ctrl(out_ctrl[0]), .out_data(out_data[0]), .count(c0));
    pipe_reg_fifo #(.DEPTH(2)) u1 (
        .clk(clk), .rset(rset), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_ctrl(out_ctrl[1]), .out_data(out_data[1]), .count(c1));
    pipe_reg_fifo #(.DEPTH(3)) u2 (
        .clk(clk), .rset(rset), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_ctrl(in_ctrl[2]), .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_ctrl(out_ctrl[2]), .out_data(out_data[2]), .count(c2));

    function automatic int cnt(int k);
        return k == 0 ? int'(c0) : k == 1 ? int'(c1) : int'(c2);
    endfunction

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [65:0] rnd_beat();
        return {2'($urandom), $urandom, $urandom};
    endfunction

    // entered just after a falling edge: drive, compare against the model, clock once, update the model
    task automatic step();
        bit mr, mv, pu [3], po [3];
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = en[k] && src[k].size() > 0;
            {in_ctrl[k], in_data[k]} = in_valid[k] ? src[k][0] : '0;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            mr = !flush[k] && q[k].size() < dep[k];
            mv = !flush[k] && q[k].size() > 0;
            check($sformatf("in_ready[d%0d]", dep[k]), 64'(in_ready[k]), 64'(mr));
            check($sformatf("out_valid[d%0d]", dep[k]), 64'(out_valid[k]), 64'(mv));
            check($sformatf("count[d%0d]", dep[k]), 64'(cnt(k)), 64'(q[k].size()));
            check($sformatf("out_data[d%0d]", dep[k]), 64'(out_data[k]), mv ? 64'(q[k][0][31:0]) : 64'd0);
            check($sformatf("out_ctrl[d%0d]", dep[k]), 64'(out_ctrl[k]), mv ? 64'(q[k][0][65:32]) : 64'd0);
            pu[k] = in_valid[k] && mr;
            po[k] = mv && out_ready[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (flush[k]) q[k].delete();
            else begin
                if (po[k]) void'(q[k].pop_front());
                if (pu[k]) q[k].push_back(src[k][0]);
            end
            if (pu[k] || (flush[k] && in_valid[k])) void'(src[k].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic idle();
        flush = '0; en = '0; out_ready = '0;
    endtask

    initial begin
        rset = 1'b0;
        idle();
        in_valid = '0;
        for (int k = 0; k < 3; k++) begin
            in_ctrl[k] = '0;
            in_data[k] = '0;
        end
        @(negedge clk);
        repeat (2) step();
        rset = 1'b1;
        step();

        // streaming 1..8 through DEPTH=2 with the sink always ready
        for (int i = 1; i <= 8; i++) src[1].push_back(66'(i));
        en[1] = 1'b1; out_ready[1] = 1'b1;
        repeat (10) step();

        // backpressure: A,B fill DEPTH=2, C held until one pop frees a slot
        idle();
        src[1].push_back({34'h1, 32'hA}); src[1].push_back({34'h2, 32'hB}); src[1].push_back({34'h3, 32'hC});
        en[1] = 1'b1;
        repeat (4) step();
        check("bp_full_count", 64'(cnt(1)), 64'd2);
        out_ready[1] = 1'b1; step();
        out_ready[1] = 1'b0; repeat (2) step();
        out_ready[1] = 1'b1; repeat (4) step();

        // flush DEPTH=3 holding two entries while a beat is offered
        idle();
        src[2].push_back(rnd_beat()); src[2].push_back(rnd_beat());
        en[2] = 1'b1; repeat (3) step();
        src[2].push_back(rnd_beat()); src[2].push_back(rnd_beat());
        flush[2] = 1'b1; out_ready[2] = 1'b1; step();
        check("flush_count", 64'(cnt(2)), 64'd0);
        flush[2] = 1'b0; repeat (3) step();

        // pointer wrap on DEPTH=3 with random sink
        idle();
        for (int i = 0; i < 10; i++) src[2].push_back(rnd_beat());
        en[2] = 1'b1;
        repeat (25) begin
            out_ready[2] = 1'($urandom_range(0, 1));
            step();
        end
        out_ready[2] = 1'b1; repeat (4) step();

        // DEPTH=1 continuous traffic alternates in_ready
        idle();
        for (int i = 0; i < 6; i++) src[0].push_back(rnd_beat());
        en[0] = 1'b1; out_ready[0] = 1'b1;
        repeat (13) step();

        // asynchronous reset with two entries buffered
        idle();
        src[1].push_back(rnd_beat()); src[1].push_back(rnd_beat());
        en[1] = 1'b1; repeat (3) step();
        check("pre_reset_count", 64'(cnt(1)), 64'd2);
        #2 rset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid[1]), 64'd0);
        check("rst_out_data", 64'(out_data[1]), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl[1]), 64'd0);
        check("rst_count", 64'(cnt(1)), 64'd0);
        check("rst_in_ready", 64'(in_ready[1]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            src[k].delete();
        end
        @(negedge clk);
        idle();
        step();
        rset = 1'b1;
        src[1].push_back({34'h0, 32'h11});
        en[1] = 1'b1;
        step();
        check("post_reset_data", 64'(out_data[1]), 64'h11);
        step();

        // random traffic on all three depths with occasional flush
        repeat (400) begin
            for (int k = 0; k < 3; k++) begin
                out_ready[k] = 1'($urandom_range(0, 1));
                flush[k] = $urandom_range(0, 19) == 0;
                en[k] = $urandom_range(0, 3) != 0;
                if (src[k].size() == 0) src[k].push_back(rnd_beat());
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
